// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
//   - state_t          : responder FSM states (IDLE, BUSY, RESP)
//   - DEFAULT_DATA_W   : default data/address width in bits
//   - DEFAULT_DEPTH    : default number of memory words
//   - DEFAULT_LATENCY  : default request-to-response latency in cycles
package mem_pkg;

  localparam int DEFAULT_DATA_W  = 64;
  localparam int DEFAULT_DEPTH   = 32;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter that times the BUSY phase of the responder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears count to 0)
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement by one; holds at zero
//   zero       : count is zero
module mem_latency_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency valid/ready request and
// response handshake. One request in flight at a time.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   req_write               : 1 = store, 0 = load
//   req_addr, req_wdata     : word address and store data
//   resp_valid / resp_ready : response handshake (valid only in RESP)
//   resp_rdata              : load data, 0 for stores and out-of-range
//   resp_err                : address was >= DEPTH
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);

  state_t state, state_nxt;

  // Holds req_ready low while reset is asserted and releases it on the
  // first clock edge after reset deasserts.
  logic out_en;

  logic cnt_load, cnt_dec, cnt_zero, do_access;

  logic              write_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] mem [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      out_en <= 1'b1;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          cnt_load  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE) && out_en;
  assign resp_valid = (state == RESP);

  mem_latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Accepted request; only meaningful while BUSY, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cnt_load) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Full-width compare so that large addresses cannot alias onto a valid
  // index through truncation.
  assign in_range = (addr_q < DEPTH_W);
  assign idx      = addr_q[IDX_W-1:0];

  // Memory and response registers: the access happens only on the
  // BUSY->RESP edge, and the result is held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (do_access) begin
      if (in_range) begin
        if (write_q) begin
          mem[idx] <= wdata_q;
        end
        resp_rdata <= write_q ? '0 : mem[idx];
        resp_err   <= 1'b0;
      end else begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder. Three instances share
// clock and reset: index 0 uses LATENCY 2, index 1 LATENCY 1, index 2 LATENCY 8.
module tb_data_mem_responder;

  localparam int LATS [3] = '{2, 1, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       req_valid, req_ready, req_write;
  logic [2:0]       resp_valid, resp_ready, resp_err;
  logic [2:0][63:0] req_addr, req_wdata, resp_rdata;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DATA_W(64), .DEPTH(32), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_mem_responder #(.DATA_W(64), .DEPTH(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  data_mem_responder #(.DATA_W(64), .DEPTH(32), .LATENCY(8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
  );

  // Issue one request on instance k and return the response. lat counts
  // clock edges from the acceptance edge to the first resp_valid sample;
  // acc is the cycle stamp of the acceptance edge. Consumes the response
  // if resp_ready is high.
  task automatic do_req(input int k, input logic wr, input logic [63:0] a,
                        input logic [63:0] d, output logic [63:0] rd,
                        output logic er, output int lat, output int acc);
    int n;
    n = 0;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid[k] = 1'b0;
    lat = 0;
    while (!resp_valid[k] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!resp_valid[k]) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout dut%0d addr %h: no resp_valid within 20 cycles", k, a);
    end
    rd = resp_rdata[k];
    er = resp_err[k];
    if (resp_ready[k]) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", req_ready[0]); end
    n_checks++; if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid[0]); end
    n_checks++; if (resp_rdata[0] !== 64'd0) begin n_fail++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata[0]); end
    n_checks++; if (resp_err[0] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got %b want 0", resp_err[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL rel_req_ready_early got %b want 0", req_ready[0]); end
    @(posedge clk); #1;
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL rel_req_ready got %b want 1", req_ready[0]); end
  endtask

  task automatic test_load_basic();
    logic [63:0] rd; logic er; int lat, acc;
    do_req(0, 1'b0, 64'd5, 64'd0, rd, er, lat, acc);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL load5_latency got %0d want 2", lat); end
    n_checks++; if (rd !== 64'd5) begin n_fail++; $display("FAIL load5_rdata got %h want 5", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL load5_err got %b want 0", er); end
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic er; int lat, acc;
    do_req(0, 1'b1, 64'd7, 64'hDEAD_BEEF, rd, er, lat, acc);
    n_checks++; if (rd !== 64'd0) begin n_fail++; $display("FAIL store7_rdata got %h want 0", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL store7_err got %b want 0", er); end
    do_req(0, 1'b0, 64'd7, 64'd0, rd, er, lat, acc);
    n_checks++; if (rd !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL load7_rdata got %h want deadbeef", rd); end
    do_req(0, 1'b0, 64'd6, 64'd0, rd, er, lat, acc);
    n_checks++; if (rd !== 64'd6) begin n_fail++; $display("FAIL load6_rdata got %h want 6", rd); end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd, exp; logic er; int lat, acc;
    do_req(0, 1'b0, 64'd32, 64'd0, rd, er, lat, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld32_err got %b want 1", er); end
    n_checks++; if (rd !== 64'd0) begin n_fail++; $display("FAIL ld32_rdata got %h want 0", rd); end
    do_req(0, 1'b0, 64'h8000_0000_0000_0000, 64'd0, rd, er, lat, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL ld2p63_err got %b want 1", er); end
    do_req(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA, rd, er, lat, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL st_ones_err got %b want 1", er); end
    n_checks++; if (rd !== 64'd0) begin n_fail++; $display("FAIL st_ones_rdata got %h want 0", rd); end
    do_req(0, 1'b1, 64'h8000_0000_0000_0000, 64'hBBBB, rd, er, lat, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL st2p63_err got %b want 1", er); end
    do_req(0, 1'b1, 64'd32, 64'hCCCC, rd, er, lat, acc);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL st32_err got %b want 1", er); end
    for (int i = 0; i < 32; i++) begin
      exp = (i == 7) ? 64'hDEAD_BEEF : 64'(i);
      do_req(0, 1'b0, 64'(i), 64'd0, rd, er, lat, acc);
      n_checks++; if (rd !== exp || er !== 1'b0) begin n_fail++; $display("FAIL mem_intact[%0d] got %h err %b want %h err 0", i, rd, er, exp); end
    end
  endtask

  task automatic test_hold();
    logic [63:0] rd; logic er; int lat, acc, n;
    resp_ready[0] = 1'b0;
    req_write[0] = 1'b0; req_addr[0] = 64'd9; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    // New request presented while the response is held: must wait for IDLE.
    req_write[0] = 1'b1; req_addr[0] = 64'd9; req_wdata[0] = 64'h1234; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 1", i, resp_valid[0]); end
      n_checks++; if (resp_rdata[0] !== 64'd9) begin n_fail++; $display("FAIL hold_rdata[%0d] got %h want 9", i, resp_rdata[0]); end
      n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready[%0d] got %b want 0", i, req_ready[0]); end
      @(posedge clk); #1;
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL hold_release got ready %b valid %b want 1 0", req_ready[0], resp_valid[0]); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL held_req_accept got ready %b want 0", req_ready[0]); end
    lat = 0;
    while (!resp_valid[0] && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL held_req_latency got %0d want 2", lat); end
    @(posedge clk); #1;
    do_req(0, 1'b0, 64'd9, 64'd0, rd, er, lat, acc);
    n_checks++; if (rd !== 64'h1234) begin n_fail++; $display("FAIL held_store_result got %h want 1234", rd); end
  endtask

  task automatic test_reset_mid_busy();
    logic [63:0] rd; logic er; int lat, acc;
    req_write[0] = 1'b1; req_addr[0] = 64'd3; req_wdata[0] = 64'h55; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n_checks++; if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL busy_state got ready %b valid %b want 0 0", req_ready[0], resp_valid[0]); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_req_ready got %b want 0", req_ready[0]); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_resp_valid got %b want 0", resp_valid[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_rel_ready got %b want 1", req_ready[0]); end
    do_req(0, 1'b0, 64'd3, 64'd0, rd, er, lat, acc);
    n_checks++; if (rd !== 64'd3) begin n_fail++; $display("FAIL aborted_store got %h want 3", rd); end
    do_req(0, 1'b0, 64'd7, 64'd0, rd, er, lat, acc);
    n_checks++; if (rd !== 64'd7) begin n_fail++; $display("FAIL mem_reinit7 got %h want 7", rd); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er; int lat, acc, prev;
    for (int k = 0; k < 3; k++) begin
      prev = 0;
      for (int i = 0; i < 32; i++) begin
        do_req(k, 1'b0, 64'(i), 64'd0, rd, er, lat, acc);
        n_checks++; if (rd !== 64'(i) || er !== 1'b0) begin n_fail++; $display("FAIL b2b_data lat%0d addr %0d got %h err %b want %h err 0", LATS[k], i, rd, er, 64'(i)); end
        n_checks++; if (lat != LATS[k]) begin n_fail++; $display("FAIL b2b_latency lat%0d addr %0d got %0d want %0d", LATS[k], i, lat, LATS[k]); end
        if (i > 0) begin
          n_checks++; if (acc - prev != LATS[k] + 2) begin n_fail++; $display("FAIL b2b_spacing lat%0d addr %0d got %0d want %0d", LATS[k], i, acc - prev, LATS[k] + 2); end
        end
        prev = acc;
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 3'b111;
    test_reset();
    test_load_basic();
    test_store_load();
    test_out_of_range();
    test_hold();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
